// File: rtl/gmii_rxctrl.sv
// gmii_rxctrl: receive-side GMII frame controller.
//
// Strips preamble/SFD from the GMII receive stream, runs the Ethernet CRC-32
// over every byte after the SFD (FCS included), holds back the last four bytes
// so the FCS never reaches the packet pipeline, and reports per-frame status
// with a one-cycle eof pulse. Good/bad frame counters update on eof.
//
// Ports:
//   clk, rst_n            receive clock, asynchronous active-low reset
//   gmii_rx_dv/er/rxd     GMII receive pins
//   grc2ppt_data_wr/data  frame byte stream (FCS removed)
//   grc2ppt_sop           first emitted byte of a frame
//   grc2ppt_eof           frame-end pulse; crc_err/len_err/gmii_err/frame_len
//                         are valid with it and hold until the next eof
//   good_frame_cnt        frames ending with no error flag (wraps)
//   bad_frame_cnt         frames ending with any error flag (wraps)
//
// Handshake: there is no backpressure. data_wr qualifies data for exactly one
// cycle; eof qualifies the status outputs for exactly one cycle.
module gmii_rxctrl #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1522
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        grc2ppt_data_wr,
    output logic [7:0]  grc2ppt_data,
    output logic        grc2ppt_sop,
    output logic        grc2ppt_eof,
    output logic        grc2ppt_crc_err,
    output logic        grc2ppt_len_err,
    output logic        grc2ppt_gmii_err,
    output logic [10:0] grc2ppt_frame_len,
    output logic [31:0] good_frame_cnt,
    output logic [31:0] bad_frame_cnt
);

    localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        PRE_S  = 2'd1,
        DATA_S = 2'd2,
        DROP_S = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        dv_r0_q, dv_r0_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] len_q, len_d;
    logic        er_q, er_d;
    logic [31:0] buf_q, buf_d;       // [31:24] is the oldest held byte
    logic        data_wr_q, data_wr_d;
    logic [7:0]  data_q, data_d;
    logic        sop_q, sop_d;
    logic        eof_q, eof_d;
    logic        crc_err_q, crc_err_d;
    logic        len_err_q, len_err_d;
    logic        gmii_err_q, gmii_err_d;
    logic [10:0] frame_len_q, frame_len_d;
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] bad_cnt_q, bad_cnt_d;

    logic        crc_bad, len_bad;

    // Reflected CRC-32 (0xEDB88320), one byte, LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Frames of four bytes or fewer carry no payload at all; they are always
    // reported as CRC errors even if the residue happens to match.
    assign crc_bad = (crc_q != RESIDUE) || (len_q <= 11'd4);
    assign len_bad = (len_q < MIN_L) || (len_q > MAX_L);

    always_comb begin
        state_d     = state_q;
        dv_r0_d     = gmii_rx_dv;
        crc_d       = crc_q;
        len_d       = len_q;
        er_d        = er_q;
        buf_d       = buf_q;
        data_wr_d   = 1'b0;
        data_d      = data_q;
        sop_d       = 1'b0;
        eof_d       = 1'b0;
        crc_err_d   = crc_err_q;
        len_err_d   = len_err_q;
        gmii_err_d  = gmii_err_q;
        frame_len_d = frame_len_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;

        case (state_q)
            IDLE_S, PRE_S: begin
                // IDLE only starts on a rising dv; PRE just needs dv held.
                if (!gmii_rx_dv) begin
                    state_d = IDLE_S;
                end else if (state_q == PRE_S || !dv_r0_q) begin
                    if (gmii_rxd == 8'h55) begin
                        state_d = PRE_S;
                    end else if (gmii_rxd == 8'hD5) begin
                        crc_d   = 32'hFFFFFFFF;
                        len_d   = 11'd0;
                        er_d    = 1'b0;
                        state_d = DATA_S;
                    end else begin
                        state_d = DROP_S;
                    end
                end
            end
            DATA_S: begin
                if (gmii_rx_dv) begin
                    crc_d = crc_byte(crc_q, gmii_rxd);
                    len_d = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
                    er_d  = er_q | gmii_rx_er;
                    buf_d = {buf_q[23:0], gmii_rxd};
                    // Four bytes already held: the oldest can no longer be FCS.
                    if (len_q >= 11'd4) begin
                        data_wr_d = 1'b1;
                        data_d    = buf_q[31:24];
                        sop_d     = (len_q == 11'd4);
                    end
                end else begin
                    eof_d       = 1'b1;
                    crc_err_d   = crc_bad;
                    len_err_d   = len_bad;
                    gmii_err_d  = er_q;
                    frame_len_d = len_q;
                    if (crc_bad || len_bad || er_q) begin
                        bad_cnt_d = bad_cnt_q + 32'd1;
                    end else begin
                        good_cnt_d = good_cnt_q + 32'd1;
                    end
                    state_d = IDLE_S;
                end
            end
            DROP_S: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE_S;
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_S;
            dv_r0_q     <= 1'b1;   // ignore a frame already running at reset release
            crc_q       <= 32'hFFFFFFFF;
            len_q       <= 11'd0;
            er_q        <= 1'b0;
            buf_q       <= 32'd0;
            data_wr_q   <= 1'b0;
            data_q      <= 8'd0;
            sop_q       <= 1'b0;
            eof_q       <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            gmii_err_q  <= 1'b0;
            frame_len_q <= 11'd0;
            good_cnt_q  <= 32'd0;
            bad_cnt_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            dv_r0_q     <= dv_r0_d;
            crc_q       <= crc_d;
            len_q       <= len_d;
            er_q        <= er_d;
            buf_q       <= buf_d;
            data_wr_q   <= data_wr_d;
            data_q      <= data_d;
            sop_q       <= sop_d;
            eof_q       <= eof_d;
            crc_err_q   <= crc_err_d;
            len_err_q   <= len_err_d;
            gmii_err_q  <= gmii_err_d;
            frame_len_q <= frame_len_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
        end
    end

    assign grc2ppt_data_wr   = data_wr_q;
    assign grc2ppt_data      = data_q;
    assign grc2ppt_sop       = sop_q;
    assign grc2ppt_eof       = eof_q;
    assign grc2ppt_crc_err   = crc_err_q;
    assign grc2ppt_len_err   = len_err_q;
    assign grc2ppt_gmii_err  = gmii_err_q;
    assign grc2ppt_frame_len = frame_len_q;
    assign good_frame_cnt    = good_cnt_q;
    assign bad_frame_cnt     = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rxctrl.sv
// Testbench for gmii_rxctrl: directed frames plus randomized frames, checked
// against a frame-level reference model (expected byte stream, cycle and
// status per frame) held in queues.
module tb_gmii_rxctrl;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        data_wr, sop, eof, crc_err, len_err, gmii_err;
    logic [7:0]  data;
    logic [10:0] frame_len;
    logic [31:0] good_cnt, bad_cnt;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gmii_rxctrl #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .gmii_rxd         (gmii_rxd),
        .grc2ppt_data_wr  (data_wr),
        .grc2ppt_data     (data),
        .grc2ppt_sop      (sop),
        .grc2ppt_eof      (eof),
        .grc2ppt_crc_err  (crc_err),
        .grc2ppt_len_err  (len_err),
        .grc2ppt_gmii_err (gmii_err),
        .grc2ppt_frame_len(frame_len),
        .good_frame_cnt   (good_cnt),
        .bad_frame_cnt    (bad_cnt)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        crc_e;
        logic        len_e;
        logic        g_e;
        logic [10:0] len;
        logic [31:0] good;
        logic [31:0] bad;
        int          cyc;
    } st_t;

    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    logic       exp_sop_q[$];
    st_t        exp_st_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         good_m = 0;
    int         bad_m = 0;
    logic [7:0] frm[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference CRC-32 of a byte sequence (standard Ethernet value with final
    // inversion); the model compares it with the FCS carried in the frame.
    function automatic logic [31:0] crc32(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ frm[k][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return ~c;
    endfunction

    always @(negedge clk) begin
        if (data_wr) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_data_wr", 1, 0);
            end else begin
                check_eq("data", data, exp_q.pop_front());
                check_eq("sop", sop, exp_sop_q.pop_front());
                check_eq("data_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (eof) begin
            if (exp_st_q.size() == 0) begin
                check_eq("unexpected_eof", 1, 0);
            end else begin
                st_t s;
                s = exp_st_q.pop_front();
                check_eq("eof_cycle", cyc, s.cyc);
                check_eq("crc_err", crc_err, s.crc_e);
                check_eq("len_err", len_err, s.len_e);
                check_eq("gmii_err", gmii_err, s.g_e);
                check_eq("frame_len", frame_len, s.len);
                check_eq("good_cnt", good_cnt, s.good);
                check_eq("bad_cnt", bad_cnt, s.bad);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(posedge clk);
        #1;
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
    endtask

    task automatic build_good(input int npay);
        logic [31:0] c;
        frm.delete();
        for (int k = 0; k < npay; k++) frm.push_back(8'($urandom_range(0, 255)));
        c = crc32(npay);
        frm.push_back(c[7:0]);
        frm.push_back(c[15:8]);
        frm.push_back(c[23:16]);
        frm.push_back(c[31:24]);
    endtask

    // Sends frm after npre preamble bytes; er_idx selects one byte driven with
    // rx_er (-1 for none); bad_pre replaces the SFD by a corrupt preamble.
    task automatic send_frame(input int npre, input int er_idx, input int gap, input bit bad_pre);
        int n;
        int last;
        st_t s;
        n = frm.size();
        if (bad_pre) begin
            drive(1, 8'h55, 0);
            drive(1, 8'h55, 0);
            drive(1, 8'hAA, 0);
        end else begin
            for (int k = 0; k < npre; k++) drive(1, 8'h55, 0);
            drive(1, 8'hD5, 0);
        end
        for (int i = 0; i < n; i++) begin
            drive(1, frm[i], (i == er_idx));
            if (!bad_pre && i >= 4) begin
                exp_q.push_back(frm[i-4]);
                exp_cyc_q.push_back(cyc + 1);
                exp_sop_q.push_back(i == 4);
            end
        end
        last = cyc;
        if (!bad_pre) begin
            logic [31:0] fcs;
            fcs = (n >= 4) ? {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} : 32'd0;
            s.crc_e = (n <= 4) || (crc32(n - 4) != fcs);
            s.len   = (n > 2047) ? 11'd2047 : 11'(n);
            s.len_e = (n < MIN_LEN) || (n > MAX_LEN);
            s.g_e   = (er_idx >= 0) && (er_idx < n);
            if (s.crc_e || s.len_e || s.g_e) bad_m++;
            else good_m++;
            s.good = 32'(good_m);
            s.bad  = 32'(bad_m);
            s.cyc  = last + 2;
            exp_st_q.push_back(s);
        end
        for (int k = 0; k < gap; k++) drive(0, 8'h00, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data_wr", data_wr, 0);
        check_eq("rst_eof", eof, 0);
        check_eq("rst_frame_len", frame_len, 0);
        check_eq("rst_good_cnt", good_cnt, 0);
        check_eq("rst_bad_cnt", bad_cnt, 0);
        rst_n = 1'b1;
        repeat (2) drive(0, 8'h00, 0);

        // "123456789" with its known FCS: CRC good, too short.
        frm.delete();
        for (int k = 0; k < 9; k++) frm.push_back(8'h31 + 8'(k));
        frm.push_back(8'h26); frm.push_back(8'h39);
        frm.push_back(8'hF4); frm.push_back(8'hCB);
        send_frame(7, -1, 3, 0);

        // Minimum-size good frame, then bit flip, then rx_er mid-frame.
        build_good(60);
        send_frame(7, -1, 1, 0);
        frm[17] = frm[17] ^ 8'h08;
        send_frame(7, -1, 2, 0);
        frm[17] = frm[17] ^ 8'h08;
        send_frame(7, 30, 2, 0);

        // Corrupt preamble is dropped; next frame after 1-cycle gap is fine.
        build_good(60);
        send_frame(7, -1, 1, 1);
        send_frame(7, -1, 1, 0);

        // Back-to-back good frames with a 1-cycle gap.
        build_good(60);
        send_frame(7, -1, 1, 0);
        build_good(60);
        send_frame(7, -1, 1, 0);

        // Tiny frame right after SFD (no preamble), over-long and saturating frames.
        frm.delete();
        frm.push_back(8'h12); frm.push_back(8'h34); frm.push_back(8'h56);
        send_frame(0, -1, 2, 0);
        build_good(1526);
        send_frame(3, -1, 2, 0);
        build_good(2096);
        send_frame(3, -1, 2, 0);

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            int sel;
            build_good($urandom_range(4, 90));
            sel = $urandom_range(0, 9);
            if (sel == 0) frm[$urandom_range(0, frm.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
            send_frame($urandom_range(0, 7), (sel == 1) ? $urandom_range(0, frm.size() - 1) : -1,
                       $urandom_range(1, 4), (sel == 2));
        end

        // Reset in the middle of a frame, released while dv is still high.
        repeat (4) drive(0, 8'h00, 0);
        for (int k = 0; k < 7; k++) drive(1, 8'h55, 0);
        drive(1, 8'hD5, 0);
        for (int k = 0; k < 3; k++) drive(1, 8'($urandom_range(0, 255)), 0);
        rst_n = 1'b0;
        good_m = 0;
        bad_m = 0;
        drive(1, 8'h77, 0);
        check_eq("midrst_good_cnt", good_cnt, 0);
        check_eq("midrst_bad_cnt", bad_cnt, 0);
        check_eq("midrst_data_wr", data_wr, 0);
        drive(1, 8'h55, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) drive(1, 8'hD5, 0);
        drive(0, 8'h00, 0);
        build_good(70);
        send_frame(7, -1, 1, 0);

        repeat (10) drive(0, 8'h00, 0);
        check_eq("leftover_data", exp_q.size(), 0);
        check_eq("leftover_eof", exp_st_q.size(), 0);
        check_eq("final_good_cnt", good_cnt, 32'(good_m));
        check_eq("final_bad_cnt", bad_cnt, 32'(bad_m));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
